// File: rtl/noc_traffic_checker_if.sv
// Receive-side AXI-Stream flit bundle between a router output port and its sink.
// Latency: none, wires only.
// Backpressure: the sink drives axis_rx_tready; the source holds a flit until tvalid & tready.
//   axis_rx_tvalid  source -> sink  flit valid
//   axis_rx_tready  sink -> source  sink can take a flit this cycle
//   axis_rx_tdata   source -> sink  flit payload (DATAW bits)
//   axis_rx_tdest   source -> sink  flit destination (DESTW bits)
interface noc_traffic_checker_if #(
    parameter int DATAW = 128,
    parameter int DESTW = 4
);
    logic             axis_rx_tvalid;
    logic             axis_rx_tready;
    logic [DATAW-1:0] axis_rx_tdata;
    logic [DESTW-1:0] axis_rx_tdest;

    modport master (
        output axis_rx_tvalid,
        output axis_rx_tdata,
        output axis_rx_tdest,
        input  axis_rx_tready
    );

    modport slave (
        input  axis_rx_tvalid,
        input  axis_rx_tdata,
        input  axis_rx_tdest,
        output axis_rx_tready
    );
endinterface

// File: rtl/noc_traffic_checker.sv
// NoC rx checker: validates src id, tdest and per-source sequence/check words of returned flits.
// Latency: statistics and done are visible 1 cycle after the accepting handshake.
// Backpressure: tready is registered, high only in RUN (LFSR-throttled when CHECKER_BACKPRESSURE_EN).
//
// Ports:
//   clk, reset       user clock, synchronous active-high reset
//   start            single-cycle pulse; arms (or re-arms from DONE) the checker
//   rx               slave side of noc_traffic_checker_if (tvalid/tready/tdata/tdest)
//   rx_count         flits accepted since start (saturating)
//   err_count        flits that failed any check (saturating)
//   err_flag         sticky error indication
//   first_err_src    src field of the first failing flit
//   first_err_code   error bits of the first failing flit {seq/chk, tdest, src range}
//   done             high while all expected flits have been received
// Build option: define CHECKER_BACKPRESSURE_EN to throttle tready with a 16-bit LFSR.
module noc_traffic_checker #(
    parameter int DATAW       = 128,
    parameter int DESTW       = 4,
    parameter int NUM_SRCS    = 4,
    parameter int SRCW        = 2,
    parameter int NUM_PACKETS = 1,
    parameter int CNTW        = 16,
    parameter int MY_DEST     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    noc_traffic_checker_if.slave  rx,
    output logic [CNTW-1:0]       rx_count,
    output logic [CNTW-1:0]       err_count,
    output logic                  err_flag,
    output logic [SRCW-1:0]       first_err_src,
    output logic [2:0]            first_err_code,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNTW-1:0]  LAST_IDX = CNTW'(NUM_SRCS * NUM_PACKETS - 1);
    localparam logic [CNTW-1:0]  CNT_MAX  = '1;
    localparam logic [DESTW-1:0] DEST_OK  = DESTW'(MY_DEST);

    state_t            state_q, state_d;
    logic [CNTW-1:0]   rx_count_q, rx_count_d;
    logic [CNTW-1:0]   err_count_q, err_count_d;
    logic              err_flag_q, err_flag_d;
    logic [SRCW-1:0]   first_err_src_q, first_err_src_d;
    logic [2:0]        first_err_code_q, first_err_code_d;
    logic              done_q, done_d;
    logic              tready_q, tready_d;
    logic [31:0]       exp_q [NUM_SRCS];
    logic [31:0]       exp_d [NUM_SRCS];

`ifdef CHECKER_BACKPRESSURE_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    logic [15:0] lfsr_q, lfsr_d;
`endif

    logic [SRCW-1:0]  src;
    logic [31:0]      seq;
    logic [31:0]      chk;
    logic [31:0]      exp_sel;
    logic             src_bad;
    logic             dest_bad;
    logic             seq_bad;
    logic [2:0]       err_code;
    logic             hs;

    always_comb begin
        src      = rx.axis_rx_tdata[DATAW-1 -: SRCW];
        seq      = rx.axis_rx_tdata[31:0];
        chk      = rx.axis_rx_tdata[63:32];
        // tready_q is only ever high in RUN, so hs implies RUN.
        hs       = rx.axis_rx_tvalid & tready_q;

        // Out-of-range src leaves exp_sel at 0; the seq check is masked then anyway.
        exp_sel  = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            if (src == SRCW'(i)) begin
                exp_sel = exp_q[i];
            end
        end

        src_bad  = (32'(src) >= 32'(NUM_SRCS));
        dest_bad = (rx.axis_rx_tdest != DEST_OK);
        seq_bad  = ~src_bad & ((seq != exp_sel) | (chk != ~seq));
        err_code = {seq_bad, dest_bad, src_bad};

        state_d          = state_q;
        rx_count_d       = rx_count_q;
        err_count_d      = err_count_q;
        err_flag_d       = err_flag_q;
        first_err_src_d  = first_err_src_q;
        first_err_code_d = first_err_code_q;
        exp_d            = exp_q;
`ifdef CHECKER_BACKPRESSURE_EN
        lfsr_d           = lfsr_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d          = S_RUN;
                    rx_count_d       = '0;
                    err_count_d      = '0;
                    err_flag_d       = 1'b0;
                    first_err_src_d  = '0;
                    first_err_code_d = '0;
                    for (int i = 0; i < NUM_SRCS; i++) begin
                        exp_d[i] = '0;
                    end
`ifdef CHECKER_BACKPRESSURE_EN
                    lfsr_d           = LFSR_SEED;
`endif
                end
            end

            S_RUN: begin
`ifdef CHECKER_BACKPRESSURE_EN
                lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
`endif
                if (hs) begin
                    if (rx_count_q != CNT_MAX) begin
                        rx_count_d = rx_count_q + 1'b1;
                    end
                    if (err_code != 3'b000) begin
                        if (err_count_q != CNT_MAX) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        err_flag_d = 1'b1;
                        if (!err_flag_q) begin
                            first_err_src_d  = src;
                            first_err_code_d = err_code;
                        end
                    end
                    // Always follow the observed sequence so one bad flit costs one error.
                    for (int i = 0; i < NUM_SRCS; i++) begin
                        if (!src_bad && (src == SRCW'(i))) begin
                            exp_d[i] = seq + 32'd1;
                        end
                    end
                    if (rx_count_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
`ifdef CHECKER_BACKPRESSURE_EN
        tready_d = (state_d == S_RUN) & (lfsr_d[0] | lfsr_d[1]);
`else
        tready_d = (state_d == S_RUN);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            rx_count_q       <= '0;
            err_count_q      <= '0;
            err_flag_q       <= 1'b0;
            first_err_src_q  <= '0;
            first_err_code_q <= '0;
            done_q           <= 1'b0;
            tready_q         <= 1'b0;
            for (int i = 0; i < NUM_SRCS; i++) begin
                exp_q[i] <= '0;
            end
`ifdef CHECKER_BACKPRESSURE_EN
            lfsr_q           <= LFSR_SEED;
`endif
        end else begin
            state_q          <= state_d;
            rx_count_q       <= rx_count_d;
            err_count_q      <= err_count_d;
            err_flag_q       <= err_flag_d;
            first_err_src_q  <= first_err_src_d;
            first_err_code_q <= first_err_code_d;
            done_q           <= done_d;
            tready_q         <= tready_d;
            exp_q            <= exp_d;
`ifdef CHECKER_BACKPRESSURE_EN
            lfsr_q           <= lfsr_d;
`endif
        end
    end

    assign rx.axis_rx_tready = tready_q;
    assign rx_count          = rx_count_q;
    assign err_count         = err_count_q;
    assign err_flag          = err_flag_q;
    assign first_err_src     = first_err_src_q;
    assign first_err_code    = first_err_code_q;
    assign done              = done_q;

endmodule

// File: tb/tb_noc_traffic_checker.sv
// Bench for noc_traffic_checker: directed vector table on a 4-source instance,
// hand-written reset/illegal-src sequences, and a randomized run on a 3-source x 16 instance.
module tb_noc_traffic_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start0, start1;

    noc_traffic_checker_if #(.DATAW(128), .DESTW(4)) if0 ();
    noc_traffic_checker_if #(.DATAW(128), .DESTW(4)) if1 ();

    logic         vld [2];
    logic [127:0] dat [2];
    logic [3:0]   dst [2];

    assign if0.axis_rx_tvalid = vld[0];
    assign if0.axis_rx_tdata  = dat[0];
    assign if0.axis_rx_tdest  = dst[0];
    assign if1.axis_rx_tvalid = vld[1];
    assign if1.axis_rx_tdata  = dat[1];
    assign if1.axis_rx_tdest  = dst[1];

    logic [15:0] rx0, err0, rx1, err1;
    logic        flag0, flag1, done0, done1;
    logic [1:0]  fsrc0, fsrc1;
    logic [2:0]  fcode0, fcode1;

    noc_traffic_checker dut0 (
        .clk(clk), .reset(reset), .start(start0), .rx(if0),
        .rx_count(rx0), .err_count(err0), .err_flag(flag0),
        .first_err_src(fsrc0), .first_err_code(fcode0), .done(done0)
    );

    noc_traffic_checker #(.NUM_SRCS(3), .NUM_PACKETS(16)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .rx(if1),
        .rx_count(rx1), .err_count(err1), .err_flag(flag1),
        .first_err_src(fsrc1), .first_err_code(fcode1), .done(done1)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit bp_seen = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 1) ? if1.axis_rx_tready : if0.axis_rx_tready;
    endfunction

    task automatic pulse_start(input int w);
        if (w == 1) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Presents one flit and returns #1 after the edge that accepts it.
    task automatic send(input int w, input logic [1:0] src, input logic [31:0] seq,
                        input logic [31:0] chk, input logic [3:0] dest, output bit ok);
        logic [127:0] d;
        bit hs;
        d          = '0;
        d[127:126] = src;
        d[63:32]   = chk;
        d[31:0]    = seq;
        vld[w] = 1'b1;
        dat[w] = d;
        dst[w] = dest;
        ok = 1'b0;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            hs = rdy(w);
            if (!hs) bp_seen = 1'b1;
            @(posedge clk); #1;
            if (hs) ok = 1'b1;
        end
        vld[w] = 1'b0;
    endtask

    typedef struct {
        bit          restart;
        logic [1:0]  src;
        logic [31:0] seq;
        logic [31:0] chk;
        logic [3:0]  dest;
        logic [15:0] e_rx;
        logic [15:0] e_err;
        logic        e_flag;
        logic [1:0]  e_fsrc;
        logic [2:0]  e_fcode;
        logic        e_done;
    } vec_t;

    vec_t tbl [12];

    // Reference model state for the randomized run on dut1.
    int          m_exp [3];
    int unsigned m_rx, m_err;
    bit          m_flag;
    int unsigned m_fsrc, m_fcode;

    initial begin
        bit ok;

        //              rs src seq     chk            dst rx err flg fs fcode   done
        tbl[0]  = '{1, 0, 32'd0, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 3'b000, 0};
        tbl[1]  = '{0, 1, 32'd0, 32'hFFFFFFFF, 0, 2, 0, 0, 0, 3'b000, 0};
        tbl[2]  = '{0, 2, 32'd0, 32'hFFFFFFFF, 0, 3, 0, 0, 0, 3'b000, 0};
        tbl[3]  = '{0, 3, 32'd0, 32'hFFFFFFFF, 0, 4, 0, 0, 0, 3'b000, 1};
        // seq jump on src 1, then resynced seq 6 is accepted as good
        tbl[4]  = '{1, 1, 32'd5, 32'hFFFFFFFA, 0, 1, 1, 1, 1, 3'b100, 0};
        tbl[5]  = '{0, 1, 32'd6, 32'hFFFFFFF9, 0, 2, 1, 1, 1, 3'b100, 0};
        tbl[6]  = '{0, 0, 32'd0, 32'hFFFFFFFF, 0, 3, 1, 1, 1, 3'b100, 0};
        tbl[7]  = '{0, 2, 32'd0, 32'hFFFFFFFF, 3, 4, 2, 1, 1, 3'b100, 1};
        // wrong tdest first, then bad chk: first error code stays 010
        tbl[8]  = '{1, 0, 32'd0, 32'hFFFFFFFF, 3, 1, 1, 1, 0, 3'b010, 0};
        tbl[9]  = '{0, 1, 32'd0, 32'h12345678, 0, 2, 2, 1, 0, 3'b010, 0};
        tbl[10] = '{0, 2, 32'd0, 32'hFFFFFFFF, 0, 3, 2, 1, 0, 3'b010, 0};
        tbl[11] = '{0, 3, 32'd0, 32'hFFFFFFFF, 0, 4, 2, 1, 0, 3'b010, 1};

        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int w = 0; w < 2; w++) begin
            vld[w] = 1'b0;
            dat[w] = '0;
            dst[w] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        cmp("reset rx_count", rx0, 0);
        cmp("reset err_count", err0, 0);
        cmp("reset err_flag", flag0, 0);
        cmp("reset done", done0, 0);
        cmp("reset tready", if0.axis_rx_tready, 0);
        cmp("reset first_err_code", fcode0, 0);

        // Directed table on dut0 (4 sources, 1 packet each).
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].restart) pulse_start(0);
            send(0, tbl[i].src, tbl[i].seq, tbl[i].chk, tbl[i].dest, ok);
            cmp($sformatf("v%0d accepted", i), ok, 1);
            cmp($sformatf("v%0d rx_count", i), rx0, tbl[i].e_rx);
            cmp($sformatf("v%0d err_count", i), err0, tbl[i].e_err);
            cmp($sformatf("v%0d err_flag", i), flag0, tbl[i].e_flag);
            cmp($sformatf("v%0d first_err_src", i), fsrc0, tbl[i].e_fsrc);
            cmp($sformatf("v%0d first_err_code", i), fcode0, tbl[i].e_fcode);
            cmp($sformatf("v%0d done", i), done0, tbl[i].e_done);
            if (tbl[i].e_done) cmp($sformatf("v%0d tready after done", i), if0.axis_rx_tready, 0);
            if (i == 3) begin
                // A flit held valid in DONE must not be taken.
                vld[0] = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                vld[0] = 1'b0;
                cmp("no accept in DONE", rx0, 4);
                cmp("done held", done0, 1);
            end
        end

        // Reset after two flits (second one bad) discards everything.
        pulse_reset();
        pulse_start(0);
        send(0, 2'd0, 32'd0, 32'hFFFFFFFF, 4'd0, ok);
        send(0, 2'd1, 32'd9, 32'hFFFFFFF6, 4'd0, ok);
        cmp("pre-reset err_count", err0, 1);
        pulse_reset();
        cmp("mid reset rx_count", rx0, 0);
        cmp("mid reset err_count", err0, 0);
        cmp("mid reset err_flag", flag0, 0);
        cmp("mid reset first_err_src", fsrc0, 0);
        cmp("mid reset first_err_code", fcode0, 0);
        cmp("mid reset done", done0, 0);
        cmp("mid reset tready", if0.axis_rx_tready, 0);
        pulse_start(0);
        for (int s = 0; s < 4; s++) send(0, 2'(s), 32'd0, 32'hFFFFFFFF, 4'd0, ok);
        cmp("after reset rx_count", rx0, 4);
        cmp("after reset err_count", err0, 0);
        cmp("after reset done", done0, 1);

        // dut1 (3 sources): src 3 is illegal; start while running is ignored.
        pulse_start(1);
        send(1, 2'd3, 32'd7, 32'hFFFFFFF8, 4'd0, ok);
        cmp("src3 rx_count", rx1, 1);
        cmp("src3 err_count", err1, 1);
        cmp("src3 first_err_src", fsrc1, 3);
        cmp("src3 first_err_code", fcode1, 3'b001);
        pulse_start(1);
        send(1, 2'd0, 32'd0, 32'hFFFFFFFF, 4'd0, ok);
        send(1, 2'd2, 32'd0, 32'hFFFFFFFF, 4'd0, ok);
        cmp("start in RUN ignored rx_count", rx1, 3);
        cmp("exp untouched by src3 err_count", err1, 1);
        cmp("first_err_code kept", fcode1, 3'b001);

        // Randomized run against the reference model.
        pulse_reset();
        pulse_start(1);
        bp_seen = 1'b0;
        for (int s = 0; s < 3; s++) m_exp[s] = 0;
        m_rx = 0; m_err = 0; m_flag = 0; m_fsrc = 0; m_fcode = 0;
        while (m_rx < 48) begin
            int unsigned src, seq, chk, dest, code;
`ifndef CHECKER_BACKPRESSURE_EN
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
`endif
            src  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            seq  = (src < 3 && $urandom_range(0, 99) < 85) ? m_exp[src] : $urandom;
            chk  = ($urandom_range(0, 9) != 0) ? ~seq : $urandom;
            dest = ($urandom_range(0, 9) != 0) ? 0 : $urandom_range(1, 15);
            send(1, 2'(src), seq, chk, 4'(dest), ok);
            cmp("rand accepted", ok, 1);
            if (!ok) break;
            code = 0;
            if (src >= 3) code += 1;
            if (dest != 0) code += 2;
            if (src < 3 && (seq != m_exp[src] || chk != ~seq)) code += 4;
            m_rx++;
            if (code != 0) begin
                m_err++;
                if (!m_flag) begin
                    m_fsrc  = src;
                    m_fcode = code;
                end
                m_flag = 1;
            end
            if (src < 3) m_exp[src] = seq + 1;
            cmp("rand rx_count", rx1, m_rx);
            cmp("rand err_count", err1, m_err);
            cmp("rand err_flag", flag1, m_flag);
            cmp("rand first_err_src", fsrc1, m_fsrc);
            cmp("rand first_err_code", fcode1, m_fcode);
            cmp("rand done", done1, (m_rx == 48) ? 1 : 0);
        end
        cmp("rand tready after done", if1.axis_rx_tready, 0);
`ifdef CHECKER_BACKPRESSURE_EN
        cmp("tready throttled in RUN", bp_seen, 1);
`else
        cmp("tready steady in RUN", bp_seen, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
